// File: rtl/hamming_pkg.sv
// Shared helpers for the SECDED Hamming decoder: position arithmetic,
// check-bit adequacy test and the error classification type.
package hamming_pkg;

    typedef enum logic [1:0] {
        LIMPO,
        SIMPLES,
        DUPLO
    } err_kind;

    localparam int MAX_POS = 4096;

    function automatic logic is_pow2(input int pos);
        return (pos > 0) && ((pos & (pos - 1)) == 0);
    endfunction

    // Data index 0 sits at the lowest non-power-of-two position (3).
    function automatic int data_pos(input int idx);
        int cnt;
        int found;
        cnt   = 0;
        found = 0;
        for (int p = 3; (p < MAX_POS) && (found == 0); p++) begin
            if (!is_pow2(p)) begin
                if (cnt == idx) found = p;
                cnt++;
            end
        end
        return found;
    endfunction

    function automatic logic par_w_adequate(input int data_w, input int par_w);
        return (longint'(1) << par_w) >= longint'(data_w + par_w + 1);
    endfunction

endpackage

// File: rtl/hamming_sindrome.sv
// Combinational syndrome and overall-parity generator for a SECDED codeword
// laid out with position 1 at the MSB and the overall parity bit at bit 0.
module hamming_sindrome
    import hamming_pkg::*;
#(
    parameter int DATA_W = 11,
    parameter int PAR_W  = 4
) (
    input  logic [DATA_W+PAR_W:0] in_cw,
    output logic [PAR_W-1:0]      syndrome,
    output logic                  parity
);

    localparam int N = DATA_W + PAR_W;

    genvar gi;
    genvar gp;
    generate
        for (gi = 0; gi < PAR_W; gi++) begin : g_syn
            logic [N:1] terms;
            for (gp = 1; gp <= N; gp++) begin : g_pos
                if (((gp >> gi) & 1) != 0) begin : g_on
                    assign terms[gp] = in_cw[N + 1 - gp];
                end else begin : g_off
                    assign terms[gp] = 1'b0;
                end
            end
            assign syndrome[gi] = ^terms;
        end
    endgenerate

    assign parity = ^in_cw;

endmodule

// File: rtl/decodifica_hamming_secded.sv
// Two-stage pipelined SECDED Hamming decoder with valid/ready handshake,
// optional correction bypass and saturating single/double error counters.
module decodifica_hamming_secded
    import hamming_pkg::*;
#(
    parameter int DATA_W = 11,
    parameter int PAR_W  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W+PAR_W:0] in_cw,
    input  logic                  corr_en,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic                  out_single,
    output logic                  out_double,
    output logic [PAR_W-1:0]      out_syndrome,
    output logic [CNT_W-1:0]      cnt_single,
    output logic [CNT_W-1:0]      cnt_double,
    input  logic                  cnt_clear
);

    localparam int N = DATA_W + PAR_W;
    localparam logic [PAR_W:0] N_POS = (PAR_W + 1)'(N);

    generate
        if (!par_w_adequate(DATA_W, PAR_W)) begin : g_par_check
            $error("PAR_W too small: 2**PAR_W must be >= DATA_W+PAR_W+1");
        end
    endgenerate

    logic [PAR_W-1:0]  syn_now;
    logic              par_now;
    logic [DATA_W-1:0] data_now;

    logic              s1_valid_reg;
    logic [DATA_W-1:0] s1_data_reg;
    logic [PAR_W-1:0]  s1_syn_reg;
    logic              s1_par_reg;
    logic              s1_corr_reg;

    logic              s2_valid_reg;
    logic [DATA_W-1:0] s2_data_reg;
    logic              s2_single_reg;
    logic              s2_double_reg;
    logic [PAR_W-1:0]  s2_syn_reg;

    logic [CNT_W-1:0]  cnt_single_reg;
    logic [CNT_W-1:0]  cnt_double_reg;

    err_kind           kind_next;
    logic              flip_next;
    logic [DATA_W-1:0] data_next;
    logic              s1_load;
    logic              s2_load;
    logic              xfer;

    hamming_sindrome #(
        .DATA_W (DATA_W),
        .PAR_W  (PAR_W)
    ) u_sindrome (
        .in_cw    (in_cw),
        .syndrome (syn_now),
        .parity   (par_now)
    );

    // Only the data positions travel past S1; check bits live on as syndrome.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_data
            localparam int POS = data_pos(gi);
            assign data_now[DATA_W-1-gi]  = in_cw[N + 1 - POS];
            assign data_next[DATA_W-1-gi] = s1_data_reg[DATA_W-1-gi]
                                          ^ (flip_next && (s1_syn_reg == PAR_W'(POS)));
        end
    endgenerate

    assign s2_load  = !s2_valid_reg || out_ready;
    assign s1_load  = !s1_valid_reg || s2_load;
    assign in_ready = s1_load;
    assign xfer     = s2_valid_reg && out_ready;

    always_comb begin
        kind_next = LIMPO;
        if (s1_syn_reg == '0) begin
            kind_next = s1_par_reg ? SIMPLES : LIMPO;
        end else if (s1_par_reg && ({1'b0, s1_syn_reg} <= N_POS)) begin
            kind_next = SIMPLES;
        end else begin
            kind_next = DUPLO;
        end
    end

    // A zero syndrome never matches a data position, so parity-bit errors flip nothing.
    assign flip_next = s1_corr_reg && (kind_next == SIMPLES);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_data_reg  <= '0;
            s1_syn_reg   <= '0;
            s1_par_reg   <= 1'b0;
            s1_corr_reg  <= 1'b0;
        end else if (s1_load) begin
            s1_valid_reg <= in_valid;
            s1_data_reg  <= data_now;
            s1_syn_reg   <= syn_now;
            s1_par_reg   <= par_now;
            s1_corr_reg  <= corr_en;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_reg  <= 1'b0;
            s2_data_reg   <= '0;
            s2_single_reg <= 1'b0;
            s2_double_reg <= 1'b0;
            s2_syn_reg    <= '0;
        end else if (s2_load) begin
            s2_valid_reg  <= s1_valid_reg;
            s2_data_reg   <= data_next;
            s2_single_reg <= (kind_next == SIMPLES);
            s2_double_reg <= (kind_next == DUPLO);
            s2_syn_reg    <= s1_syn_reg;
        end
    end

    // Clear wins over a same-cycle transfer; counts stick at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_single_reg <= '0;
            cnt_double_reg <= '0;
        end else if (cnt_clear) begin
            cnt_single_reg <= '0;
            cnt_double_reg <= '0;
        end else if (xfer) begin
            if (s2_single_reg && (cnt_single_reg != '1))
                cnt_single_reg <= cnt_single_reg + CNT_W'(1);
            if (s2_double_reg && (cnt_double_reg != '1))
                cnt_double_reg <= cnt_double_reg + CNT_W'(1);
        end
    end

    assign out_valid    = s2_valid_reg;
    assign out_data     = s2_data_reg;
    assign out_single   = s2_single_reg;
    assign out_double   = s2_double_reg;
    assign out_syndrome = s2_syn_reg;
    assign cnt_single   = cnt_single_reg;
    assign cnt_double   = cnt_double_reg;

endmodule

// File: tb/tb_decodifica_hamming_secded.sv
// Self-checking bench: words are encoded by a reference Hamming encoder, errors
// are injected at known positions and the expected outcome follows from them.
module tb_decodifica_hamming_secded;

    localparam int DW = 11;
    localparam int PW = 4;
    localparam int NP = DW + PW;
    localparam int CW = NP + 1;

    typedef struct {
        logic [DW-1:0] data;
        logic          single;
        logic          dbl;
        logic [PW-1:0] syn;
    } exp_t;

    typedef struct {
        logic [CW-1:0] cw;
        logic          ce;
        exp_t          e;
    } word_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid, in_ready, corr_en, out_valid, out_ready, cnt_clear;
    logic [CW-1:0] in_cw;
    logic [DW-1:0] out_data;
    logic          out_single, out_double;
    logic [PW-1:0] out_syndrome;
    logic [15:0]   cnt_single, cnt_double;

    logic          in_ready_s, out_valid_s, out_single_s, out_double_s;
    logic [DW-1:0] out_data_s;
    logic [PW-1:0] out_syndrome_s;
    logic [1:0]    cnt_single_s, cnt_double_s;

    always #5 clk = ~clk;

    decodifica_hamming_secded #(.DATA_W(DW), .PAR_W(PW), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_cw(in_cw), .corr_en(corr_en), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_single(out_single), .out_double(out_double),
        .out_syndrome(out_syndrome), .cnt_single(cnt_single), .cnt_double(cnt_double),
        .cnt_clear(cnt_clear)
    );

    decodifica_hamming_secded #(.DATA_W(DW), .PAR_W(PW), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_cw(in_cw), .corr_en(corr_en), .out_valid(out_valid_s), .out_ready(out_ready),
        .out_data(out_data_s), .out_single(out_single_s), .out_double(out_double_s),
        .out_syndrome(out_syndrome_s), .cnt_single(cnt_single_s), .cnt_double(cnt_double_s),
        .cnt_clear(cnt_clear)
    );

    int     n_checks = 0;
    int     n_errors = 0;
    int     m_cs = 0;
    int     m_cd = 0;
    exp_t   sb[$];
    word_t  pend[$];
    word_t  idle_w;
    logic   last_ov, last_ir, last_acc;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, expv);
        end
    endtask

    function automatic logic [31:0] sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return 32'((v > mx) ? mx : v);
    endfunction

    function automatic logic [CW-1:0] encode(input logic [DW-1:0] d);
        logic [NP:0]   pb;
        logic [CW-1:0] cw;
        logic          par;
        int            di;
        pb = '0;
        cw = '0;
        di = DW - 1;
        for (int p = 1; p <= NP; p++)
            if ((p & (p - 1)) != 0) begin
                pb[p] = d[di];
                di--;
            end
        for (int k = 0; k < PW; k++) begin
            par = 1'b0;
            for (int p = 1; p <= NP; p++)
                if ((((p >> k) & 1) != 0) && (p != (1 << k))) par = par ^ pb[p];
            pb[1 << k] = par;
        end
        for (int p = 1; p <= NP; p++) cw[CW - p] = pb[p];
        cw[0] = ^cw[CW-1:1];
        return cw;
    endfunction

    function automatic logic [DW-1:0] get_data(input logic [CW-1:0] cw);
        logic [DW-1:0] d;
        int            di;
        d  = '0;
        di = DW - 1;
        for (int p = 1; p <= NP; p++)
            if ((p & (p - 1)) != 0) begin
                d[di] = cw[CW - p];
                di--;
            end
        return d;
    endfunction

    // Position 0 denotes the overall parity bit.
    function automatic word_t make_word(input logic [DW-1:0] d, input int nflip, input logic ce);
        word_t w;
        int    q1, q2;
        w.cw = encode(d);
        q1 = $urandom_range(0, NP);
        q2 = q1;
        while (q2 == q1) q2 = $urandom_range(0, NP);
        if (nflip >= 1) w.cw[(q1 == 0) ? 0 : CW - q1] = ~w.cw[(q1 == 0) ? 0 : CW - q1];
        if (nflip >= 2) w.cw[(q2 == 0) ? 0 : CW - q2] = ~w.cw[(q2 == 0) ? 0 : CW - q2];
        w.ce       = ce;
        w.e.data   = d;
        w.e.single = 1'b0;
        w.e.dbl    = 1'b0;
        w.e.syn    = '0;
        if (nflip == 1) begin
            w.e.single = 1'b1;
            w.e.syn    = PW'(q1);
            w.e.data   = ce ? d : get_data(w.cw);
        end else if (nflip >= 2) begin
            w.e.dbl  = 1'b1;
            w.e.syn  = PW'(q1 ^ q2);
            w.e.data = get_data(w.cw);
        end
        return w;
    endfunction

    function automatic word_t mk_dir(input logic [CW-1:0] cw, input logic ce, input logic [DW-1:0] d,
                                     input logic s, input logic db, input logic [PW-1:0] syn);
        word_t w;
        w.cw = cw; w.ce = ce;
        w.e.data = d; w.e.single = s; w.e.dbl = db; w.e.syn = syn;
        return w;
    endfunction

    task automatic step(input logic iv, input word_t w, input logic ordy, input logic clr);
        exp_t h;
        logic xfer;
        @(negedge clk);
        check_eq("cnt_single", 32'(cnt_single), sat(m_cs, 16));
        check_eq("cnt_double", 32'(cnt_double), sat(m_cd, 16));
        check_eq("cnt_single_w2", 32'(cnt_single_s), sat(m_cs, 2));
        check_eq("cnt_double_w2", 32'(cnt_double_s), sat(m_cd, 2));
        in_valid  = iv;
        in_cw     = iv ? w.cw : CW'($urandom);
        corr_en   = w.ce;
        out_ready = ordy;
        cnt_clear = clr;
        #1;
        last_ov  = out_valid;
        last_ir  = in_ready;
        last_acc = iv && in_ready;
        xfer     = 1'b0;
        if (out_valid) begin
            if (sb.size() == 0) begin
                check_eq("spurious_valid", 32'(out_valid), 32'd0);
            end else begin
                h = sb[0];
                check_eq("out_data", 32'(out_data), 32'(h.data));
                check_eq("out_single", 32'(out_single), 32'(h.single));
                check_eq("out_double", 32'(out_double), 32'(h.dbl));
                check_eq("out_syndrome", 32'(out_syndrome), 32'(h.syn));
                if (ordy) begin
                    void'(sb.pop_front());
                    xfer = 1'b1;
                end
            end
        end
        if (clr) begin
            m_cs = 0;
            m_cd = 0;
        end else if (xfer) begin
            if (h.single) m_cs++;
            if (h.dbl) m_cd++;
        end
        if (last_acc) sb.push_back(w.e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        cnt_clear = 1'b0;
        #1;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_data", 32'(out_data), 32'd0);
        check_eq("rst_flags", 32'({out_single, out_double}), 32'd0);
        check_eq("rst_syndrome", 32'(out_syndrome), 32'd0);
        check_eq("rst_cnt_single", 32'(cnt_single), 32'd0);
        check_eq("rst_cnt_double", 32'(cnt_double), 32'd0);
        sb.delete();
        m_cs = 0;
        m_cd = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_pend(input int ordy_pct, input int clr_pct, input int reset_at);
        int    cyc;
        logic  iv;
        word_t w;
        cyc = 0;
        while (((pend.size() > 0) || (sb.size() > 0)) && (cyc < 20000)) begin
            if (cyc == reset_at) do_reset();
            w  = (pend.size() > 0) ? pend[0] : idle_w;
            iv = (pend.size() > 0) && ($urandom_range(0, 99) < 80);
            step(iv, w, ($urandom_range(0, 99) < ordy_pct), ($urandom_range(0, 99) < clr_pct));
            if (last_acc) void'(pend.pop_front());
            cyc++;
        end
        check_eq("drain_left", 32'(pend.size() + sb.size()), 32'd0);
    endtask

    initial begin
        int nacc;
        idle_w    = mk_dir('0, 1'b1, '0, 1'b0, 1'b0, '0);
        in_valid  = 1'b0;
        in_cw     = '0;
        corr_en   = 1'b1;
        out_ready = 1'b1;
        cnt_clear = 1'b0;
        do_reset();

        // Latency: accepted word appears exactly two cycles later.
        step(1'b1, mk_dir(16'hFFFF, 1'b1, 11'h7FF, 1'b0, 1'b0, 4'd0), 1'b1, 1'b0);
        step(1'b0, idle_w, 1'b1, 1'b0);
        check_eq("lat_cycle1", 32'(last_ov), 32'd0);
        step(1'b0, idle_w, 1'b1, 1'b0);
        check_eq("lat_cycle2", 32'(last_ov), 32'd1);

        step(1'b1, mk_dir(16'hF7FF, 1'b1, 11'h7FF, 1'b1, 1'b0, 4'd5), 1'b1, 1'b0);
        check_eq("tput_acc0", 32'(last_acc), 32'd1);
        step(1'b1, mk_dir(16'hF7FF, 1'b0, 11'h5FF, 1'b1, 1'b0, 4'd5), 1'b1, 1'b0);
        check_eq("tput_acc1", 32'(last_acc), 32'd1);
        step(1'b1, mk_dir(16'hD7FF, 1'b1, 11'h1FF, 1'b0, 1'b1, 4'd6), 1'b1, 1'b0);
        check_eq("tput_acc2", 32'(last_acc), 32'd1);
        step(1'b1, mk_dir(16'hFFFE, 1'b1, 11'h7FF, 1'b1, 1'b0, 4'd0), 1'b1, 1'b0);
        check_eq("tput_acc3", 32'(last_acc), 32'd1);
        repeat (3) step(1'b0, idle_w, 1'b1, 1'b0);
        check_eq("dir_cnt_single", 32'(cnt_single), 32'd3);
        check_eq("dir_cnt_double", 32'(cnt_double), 32'd1);

        // Backpressure: two words fill the pipe, then in_ready drops.
        for (int i = 0; i < 4; i++) pend.push_back(make_word(DW'($urandom), 0, 1'b1));
        nacc = 0;
        for (int k = 0; k < 3; k++) begin
            step(1'b1, pend[0], 1'b0, 1'b0);
            if (last_acc) begin
                void'(pend.pop_front());
                nacc++;
            end
        end
        check_eq("bp_accepts", 32'(nacc), 32'd2);
        check_eq("bp_in_ready", 32'(last_ir), 32'd0);
        check_eq("bp_out_valid", 32'(last_ov), 32'd1);
        run_pend(100, 0, -1);

        // Saturation of the 2-bit counter after five single errors.
        do_reset();
        for (int i = 0; i < 5; i++) pend.push_back(make_word(DW'($urandom), 1, 1'($urandom)));
        run_pend(100, 0, -1);
        step(1'b0, idle_w, 1'b1, 1'b0);
        check_eq("sat_cnt_w2", 32'(cnt_single_s), 32'd3);
        check_eq("sat_cnt_w16", 32'(cnt_single), 32'd5);

        // Clear coinciding with a transfer leaves counters at zero.
        pend.push_back(make_word(DW'($urandom), 1, 1'b1));
        for (int k = 0; (k < 10) && !(last_ov === 1'b1); k++) begin
            step(pend.size() > 0, (pend.size() > 0) ? pend[0] : idle_w, 1'b0, 1'b0);
            if (last_acc) void'(pend.pop_front());
        end
        check_eq("clr_wait_valid", 32'(last_ov), 32'd1);
        step(1'b0, idle_w, 1'b1, 1'b1);
        step(1'b0, idle_w, 1'b1, 1'b0);
        check_eq("clr_cnt_w16", 32'(cnt_single), 32'd0);
        check_eq("clr_cnt_w2", 32'(cnt_single_s), 32'd0);

        // Random traffic with stalls, occasional clears and a mid-stream reset.
        for (int i = 0; i < 300; i++)
            pend.push_back(make_word(DW'($urandom), $urandom_range(0, 2), 1'($urandom)));
        run_pend(70, 2, 150);
        for (int i = 0; i < 100; i++)
            pend.push_back(make_word(DW'($urandom), $urandom_range(0, 2), 1'($urandom)));
        run_pend(50, 0, -1);
        step(1'b0, idle_w, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/decodifica_hamming_secded.md
Name: decodifica_hamming_secded

Overview:
- Parametrised, pipelined SECDED Hamming decoder; successor to the fixed 15/11 single-error corrector.
- Generic data width plus an extra overall-parity bit, so double errors are detected.
- Valid/ready stream handshake with backpressure, optional correction bypass, and saturating error counters.
- Sits between a memory/link read port and the consumer of the recovered data words.

Parameters:
- DATA_W, 11: data bits per word.
- PAR_W, 4: Hamming check bits; must satisfy 2**PAR_W >= DATA_W+PAR_W+1 (elaboration error otherwise).
- CNT_W, 16: width of each error counter.
- Derived, not overridable: N = DATA_W+PAR_W (Hamming positions); CW_W = N+1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  in_cw holds a codeword.
- in_ready  out  1  decoder accepts a codeword this cycle.
- in_cw  in  CW_W  codeword; position p (1..N) at bit N+1-p (MSB = position 1); bit 0 = overall even parity of all CW_W bits.
- corr_en  in  1  1 = correct single errors, 0 = detect only; sampled with the word.
- out_valid  out  1  output word valid.
- out_ready  in  1  consumer accepts.
- out_data  out  DATA_W  data bits, MSB = lowest non-power-of-two position (pos 3), LSB = position N.
- out_single  out  1  single error detected (corrected if corr_en was 1).
- out_double  out  1  uncorrectable error.
- out_syndrome  out  PAR_W  raw syndrome of the word.
- cnt_single  out  CNT_W  count of transferred words with out_single=1.
- cnt_double  out  CNT_W  count of transferred words with out_double=1.
- cnt_clear  in  1  synchronous clear of both counters.

Behaviour:
- Reset (rst_n=0): all valids 0, all outputs and counters 0; in-flight words discarded. Mid-stream reset needs no drain.
- Pipeline: S1 registers codeword, syndrome, overall parity and corr_en. S2 registers corrected data and flags.
- Latency is 2 cycles from accept to out_valid with no stall; throughput is 1 word/cycle.
- Stage advance: S2 loads when !s2_valid or out_ready; S1 loads when S1 is empty or S2 loads.
- in_ready = !s1_valid || s2_load (combinational path from out_ready allowed).
- Outputs stay stable while out_valid && !out_ready.
- Syndrome bit k = XOR of positions p with bit k of p set. P = XOR of all CW_W bits.
- Classification:
  - s=0, P=0: clean.
  - s=0, P=1: parity-bit error; out_single=1, data unchanged.
  - s in 1..N, P=1: single error; flip position s if corr_en.
  - s!=0, P=0: double error; out_double=1.
  - s>N, P=1: out_double=1.
- out_single and out_double are never both 1. On out_double, data passes uncorrected.
- corr_en=0: flags and syndrome are identical to corr_en=1, but no bit is flipped.
- Counters update only on output transfer (out_valid && out_ready), saturate at all-ones, and do not wrap.
- cnt_clear has priority: counters go to 0 and a same-cycle transfer is not counted.

Decomposition:
- Package hamming_pkg:
  - function is_pow2(pos);
  - function data_pos(i), mapping data index to codeword position;
  - localparam check helper for PAR_W adequacy;
  - enum err_kind {LIMPO, SIMPLES, DUPLO}.
- Sub-module hamming_sindrome: combinational, parametrised by DATA_W/PAR_W. Inputs in_cw; outputs syndrome and overall parity. Instantiated ahead of S1.

Test Plan (DATA_W=11, PAR_W=4):
- 16'hFFFF, corr_en=1 -> after 2 cycles: out_data=11'h7FF, single=0, double=0, syndrome=0.
- 16'hF7FF (pos 5 flipped), corr_en=1 -> data=11'h7FF, single=1, syndrome=5, cnt_single=1. Same word with corr_en=0 -> data=11'h5FF, single=1.
- 16'hD7FF (pos 3 and 5 flipped) -> double=1, single=0, syndrome=6, data=11'h1FF, cnt_double increments.
- 16'hFFFE (overall parity bit flipped) -> data=11'h7FF, single=1, syndrome=0.
- Backpressure: stream 4 words, hold out_ready=0 for 3 cycles -> in_ready falls after 2 accepts, out_* stable, order preserved, no loss or duplication.
- CNT_W=2: 5 single-error transfers -> cnt_single=3 (saturated). cnt_clear together with a transfer -> 0. rst_n pulse mid-stream -> out_valid=0 next cycle, counters=0.
